muldiv_ctrl: RTL

//   Execute-stage sequencer for the iterative multiplier and divider. Accepts one
//   mul/div op per valid/ready handshake, starts the matching unit and holds operands

---
 rtl/muldiv_ctrl_if.sv | 41 ++++
 rtl/muldiv_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: bundles the pipeline-side request/response handshake and the
// unit-side start/kill/done signals of the mul/div execute-stage sequencer.
//   slave  : controller view (muldiv_ctrl)
//   master : environment view (pipeline + iterative units)
interface muldiv_ctrl_if;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        resp_err;
  logic        mul_start;
  logic        div_start;
  logic        unit_kill;
  logic [2:0]  unit_op;
  logic [63:0] unit_a;
  logic [63:0] unit_b;
  logic        mul_done;
  logic        div_done;
  logic [63:0] mul_res;
  logic [63:0] div_res;
  logic [31:0] busy_cycles;

  modport slave (
    input  flush, req_valid, req_op, req_a, req_b, resp_ready,
           mul_done, div_done, mul_res, div_res,
    output req_ready, resp_valid, resp_data, resp_err,
           mul_start, div_start, unit_kill, unit_op, unit_a, unit_b, busy_cycles
  );

  modport master (
    output flush, req_valid, req_op, req_a, req_b, resp_ready,
           mul_done, div_done, mul_res, div_res,
    input  req_ready, resp_valid, resp_data, resp_err,
           mul_start, div_start, unit_kill, unit_op, unit_a, unit_b, busy_cycles
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: execute-stage sequencer for the iterative multiplier/divider.
// Accepts one op per req handshake, latches op/operands onto unit_op/a/b, pulses the
// matching start, waits for done (ignoring done in the start cycle), and holds the
// result until the pipeline takes it. Divide-by-zero is answered locally. A watchdog
// aborts a unit that runs TIMEOUT busy cycles; flush aborts anything in flight.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : muldiv_ctrl_if.slave (request, response, unit control, busy_cycles)
module muldiv_ctrl #(
  parameter int unsigned TIMEOUT = 200
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL_BUSY, S_DIV_BUSY, S_HOLD} state_t;

  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        first_q, first_d;     // first BUSY cycle: start pulse, done ignored
  logic [31:0] wd_q, wd_d;           // busy cycles already spent on this op
  logic [63:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [31:0] busy_q, busy_d;
  logic        mul_start_c, div_start_c, kill_c;
  logic        in_busy, unit_done, accept;
  logic [63:0] unit_res;

  // Ops 6/7 are word ops: only the low 32 bits of the divisor matter.
  function automatic logic div_by_zero(input logic [2:0] op, input logic [63:0] b);
    if (op < 3'd2)  return 1'b0;
    if (op >= 3'd6) return (b[31:0] == 32'd0);
    return (b == 64'd0);
  endfunction

  function automatic logic [63:0] dz_result(input logic [2:0] op, input logic [63:0] a);
    case (op)
      3'd4, 3'd5: return a;
      3'd7:       return {{32{a[31]}}, a[31:0]};
      default:    return '1;
    endcase
  endfunction

  assign in_busy   = (state_q == S_MUL_BUSY) || (state_q == S_DIV_BUSY);
  assign unit_done = (state_q == S_MUL_BUSY) ? bus.mul_done : bus.div_done;
  assign unit_res  = (state_q == S_MUL_BUSY) ? bus.mul_res  : bus.div_res;
  assign accept    = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d     = state_q;
    first_d     = 1'b0;
    wd_d        = wd_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = (in_busy && (busy_q != '1)) ? busy_q + 32'd1 : busy_q;
    mul_start_c = 1'b0;
    div_start_c = 1'b0;
    kill_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d       = bus.req_op;
          a_d        = bus.req_a;
          b_d        = bus.req_b;
          wd_d       = '0;
          resp_err_d = 1'b0;
          if (bus.req_op <= 3'd1) begin
            state_d = S_MUL_BUSY;
            first_d = 1'b1;
          end else if (div_by_zero(bus.req_op, bus.req_b)) begin
            state_d     = S_HOLD;
            resp_data_d = dz_result(bus.req_op, bus.req_a);
          end else begin
            state_d = S_DIV_BUSY;
            first_d = 1'b1;
          end
        end
      end
      S_MUL_BUSY, S_DIV_BUSY: begin
        wd_d        = wd_q + 32'd1;
        mul_start_c = first_q && (state_q == S_MUL_BUSY);
        div_start_c = first_q && (state_q == S_DIV_BUSY);
        // A real result beats the watchdog if both land in the same cycle.
        if (!first_q && unit_done) begin
          resp_data_d = unit_res;
          state_d     = S_HOLD;
        end else if (wd_q == WD_LAST) begin
          kill_c      = 1'b1;
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.resp_ready) begin
          state_d    = S_IDLE;
          resp_err_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides everything: no start, result discarded, unit aborted.
    if (bus.flush) begin
      state_d     = S_IDLE;
      first_d     = 1'b0;
      resp_err_d  = 1'b0;
      resp_data_d = resp_data_q;
      mul_start_c = 1'b0;
      div_start_c = 1'b0;
      kill_c      = in_busy;
    end

    // The reset cycle never emits unit pulses.
    if (reset) begin
      mul_start_c = 1'b0;
      div_start_c = 1'b0;
      kill_c      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      first_q     <= 1'b0;
      wd_q        <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      wd_q        <= wd_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE) && !bus.flush;
  assign bus.resp_valid  = (state_q == S_HOLD);
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.mul_start   = mul_start_c;
  assign bus.div_start   = div_start_c;
  assign bus.unit_kill   = kill_c;
  assign bus.unit_op     = op_q;
  assign bus.unit_a      = a_q;
  assign bus.unit_b      = b_q;
  assign bus.busy_cycles = busy_q;

endmodule
